// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deserialiser,
// frame checker with inactivity timeout, and a scan-code FIFO for MMIO reads.
module ps2_kb_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       sig_rd_kb,
    output logic [7:0] kb_data,
    output logic       kb_ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int KbWidth = 8;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW:0]   Full    = (PW + 1)'(FIFO_DEPTH);

    logic [2:0]         clk_sync;
    logic [1:0]         data_sync;
    logic               fall;
    logic               bit_in;

    logic [3:0]         cnt, cnt_n;
    logic [8:0]         shift, shift_n;
    logic [TW-1:0]      tmo, tmo_n;
    logic               push;
    logic               err_n;

    logic [KbWidth-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [PW:0]        count;
    logic               full;
    logic               pop;
    logic               wr_en;

    // Idle bus is high, so resetting the synchronisers to 1 never fakes an edge.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[1];

    always_comb begin
        cnt_n   = cnt;
        shift_n = shift;
        tmo_n   = tmo;
        push    = 1'b0;
        err_n   = 1'b0;
        if (fall) begin
            tmo_n = '0;
            if (cnt == 4'd0) begin
                if (!bit_in) cnt_n = 4'd1;
            end else if (cnt != 4'd10) begin
                shift_n = {bit_in, shift[8:1]};
                cnt_n   = cnt + 4'd1;
            end else begin
                cnt_n = 4'd0;
                // shift holds {parity, D7..D0}; odd parity over all nine bits
                if (bit_in && (^shift)) push  = 1'b1;
                else                    err_n = 1'b1;
            end
        end else if (cnt != 4'd0) begin
            if (tmo == TmoLast) begin
                cnt_n = 4'd0;
                tmo_n = '0;
                err_n = 1'b1;
            end else begin
                tmo_n = tmo + TW'(1);
            end
        end else begin
            tmo_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            cnt       <= '0;
            shift     <= '0;
            tmo       <= '0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            shift     <= shift_n;
            tmo       <= tmo_n;
            frame_err <= err_n;
        end
    end

    assign kb_ready = (count != '0);
    assign full     = (count == Full);
    assign pop      = sig_rd_kb & kb_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign wr_en    = push & (~full | pop);
    assign kb_data  = kb_ready ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (clrn && wr_en) mem[wr_ptr] <= shift[7:0];
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !pop)      count <= count + (PW + 1)'(1);
            else if (!wr_en && pop) count <= count - (PW + 1)'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_kb_rx.sv
// Randomised scoreboard bench for ps2_kb_rx: the stimulus side records expected
// scan codes in a queue, a negedge monitor checks every pop against it.
module tb_ps2_kb_rx;
    localparam int DEPTH = 8;
    localparam int TMO   = 300;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       sig_rd_kb = 1'b0;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       overflow;
    logic       frame_err;

    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    int         err_exp = 0;
    bit         ovf_exp = 1'b0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    ps2_kb_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .clrn(clrn),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .sig_rd_kb(sig_rd_kb),
        .kb_data(kb_data),
        .kb_ready(kb_ready),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: each cycle a pop is presented, the head must match the model.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
        if (kb_ready === 1'b1 && sig_rd_kb) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected empty", kb_data);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                if (kb_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", kb_data, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int nbits,
                              input bit pop_at_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(5);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                tick(2);
                sig_rd_kb = 1'b1;
                tick(1);
                sig_rd_kb = 1'b0;
                tick(7);
            end else begin
                tick(10);
            end
            ps2_clk = 1'b1;
            tick(5);
        end
        ps2_data = 1'b1;
        if (nbits == 11) begin
            if (!bad_par && !bad_stop) begin
                if (pop_at_stop || q.size() < DEPTH) q.push_back(b);
                else ovf_exp = 1'b1;
            end else begin
                err_exp++;
            end
        end
        tick(3);
    endtask

    task automatic read_n(input int n);
        sig_rd_kb = 1'b1;
        tick(n);
        sig_rd_kb = 1'b0;
        tick(1);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".ready"}, int'(kb_ready), int'(q.size() != 0));
        check({tag, ".data"}, int'(kb_data), q.size() != 0 ? int'(q[0]) : 0);
        check({tag, ".overflow"}, int'(overflow), int'(ovf_exp));
        check({tag, ".frame_err"}, err_seen, err_exp);
    endtask

    task automatic do_reset(input int n);
        clrn = 1'b0;
        tick(n);
        clrn = 1'b1;
        q.delete();
        ovf_exp = 1'b0;
        tick(1);
    endtask

    initial begin
        tick(2);
        check_state("reset");
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        q.delete();
        clrn = 1'b1;
        tick(2);
        check_state("reset_toggle");

        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        check_state("good_1c");
        read_n(1);
        check_state("pop_1c");

        send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        check_state("two_frames");
        read_n(1);
        check_state("two_pop1");
        read_n(1);
        check_state("two_pop2");
        for (int i = 0; i < 10; i++) begin
            send_frame(8'($urandom), 1'b0, 1'b0, 11, 1'b0);
            read_n(1);
        end
        check_state("wrap");

        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
        check_state("bad_parity");
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        check_state("bad_stop");

        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b0, 11, 1'b0);
        check_state("overflow");
        read_n(8);
        check_state("drain");

        do_reset(2);
        for (int k = 0; k < DEPTH; k++)
            send_frame(8'($urandom), 1'b0, 1'b0, 11, 1'b0);
        send_frame(8'($urandom), 1'b0, 1'b0, 11, 1'b1);
        check_state("full_push_pop");
        read_n(8);
        check_state("full_drain");

        send_frame(8'h5A, 1'b0, 1'b0, 4, 1'b0);
        tick(TMO + 20);
        err_exp++;
        check_state("timeout");
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b0);
        check_state("after_timeout");
        read_n(1);

        send_frame(8'h33, 1'b0, 1'b0, 5, 1'b0);
        do_reset(2);
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b0);
        check_state("mid_reset");
        read_n(1);
        check_state("mid_reset_pop");

        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 4);
            if (r <= 1)      send_frame(8'($urandom), 1'b0, 1'b0, 11, 1'b0);
            else if (r == 2) send_frame(8'($urandom), 1'b1, 1'b0, 11, 1'b0);
            else if (r == 3) send_frame(8'($urandom), 1'b0, 1'b1, 11, 1'b0);
            else             read_n($urandom_range(1, 3));
            check_state($sformatf("rand%0d", i));
        end
        read_n(DEPTH + 1);
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
